// File: rtl/ffd_pkg.sv
// Shared constants and helpers for the ffd_delay_line family.
package ffd_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth inclusive.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ffd_stage.sv
// One {valid, data} register of the delay line: async active-low reset, enable,
// and an optional synchronous clear (FFD_SYNC_CLR_EN).
module ffd_stage
  import ffd_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
`ifdef FFD_SYNC_CLR_EN
  input  logic           clr,
`endif
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] q
);

  localparam logic [WIDTH:0] EMPTY_WORD = {1'b0, RESET_VAL};

  logic [WIDTH:0] word_q;
  logic [WIDTH:0] word_d;

  // NOTE: default assignment first so every path assigns word_d -- no latch.
  always_comb begin
    word_d = word_q;
    if (en) word_d = d;
`ifdef FFD_SYNC_CLR_EN
    if (clr) word_d = EMPTY_WORD;
`endif
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_q <= EMPTY_WORD;
    else        word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/ffd_delay_line.sv
// WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid and occupancy count.
// Optional synchronous clear port `clr` is compiled in with FFD_SYNC_CLR_EN.
module ffd_delay_line
  import ffd_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = fill_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enabled,
`ifdef FFD_SYNC_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    fill,
  output logic             full
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stage_in  [DEPTH];
  stage_t stage_out [DEPTH];

  assign stage_in[0] = '{valid: d_valid, data: d};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_in[k] = stage_out[k-1];
    end

    ffd_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (enabled),
`ifdef FFD_SYNC_CLR_EN
      .clr   (clr),
`endif
      .d     (stage_in[k]),
      .q     (stage_out[k])
    );
  end

  assign q       = stage_out[DEPTH-1].data;
  assign q_valid = stage_out[DEPTH-1].valid;

  // Occupancy tracks entering vs. leaving valid words; it cannot exceed DEPTH.
  logic [CW-1:0] fill_q, fill_d;
  logic          full_q, full_d;

  always_comb begin
    fill_d = fill_q;
    if (enabled) begin
      case ({d_valid, q_valid})
        2'b10:   fill_d = fill_q + CW'(1);
        2'b01:   fill_d = fill_q - CW'(1);
        default: ;
      endcase
    end
`ifdef FFD_SYNC_CLR_EN
    if (clr) fill_d = '0;
`endif
    full_d = (fill_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign fill = fill_q;
  assign full = full_q;

endmodule

// File: tb/tb_ffd_delay_line.sv
// Scoreboard bench for ffd_delay_line: DEPTH=4 main instance plus a DEPTH=1 instance.
module tb_ffd_delay_line;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enabled = 1'b0;
  logic         d_valid = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] d = '0;

  logic [W-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] fill;
  logic          full;

  logic [W-1:0]  q1;
  logic          q1_valid;
  logic          fill1;
  logic          full1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  ffd_delay_line #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .enabled (enabled),
`ifdef FFD_SYNC_CLR_EN
    .clr     (clr),
`endif
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .fill    (fill),
    .full    (full)
  );

  ffd_delay_line #(.WIDTH(W), .DEPTH(1), .RESET_VAL('0)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .enabled (enabled),
`ifdef FFD_SYNC_CLR_EN
    .clr     (clr),
`endif
    .d       (d),
    .d_valid (d_valid),
    .q       (q1),
    .q_valid (q1_valid),
    .fill    (fill1),
    .full    (full1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string tag, input logic [W-1:0] eq, input logic eqv,
                              input logic [CW-1:0] efill, input logic efull);
    check({tag, "_q"},       q,       eq);
    check({tag, "_q_valid"}, q_valid, eqv);
    check({tag, "_fill"},    fill,    efill);
    check({tag, "_full"},    full,    efull);
  endtask

  // Inputs change on the falling edge; returns 1 time unit after the next rising edge.
  task automatic drive(input logic en, input logic dv, input logic [W-1:0] dd);
    @(negedge clk);
    enabled = en;
    d_valid = dv;
    d       = dd;
    if (en && dv && reset && !clr) exp_q.push_back(dd);
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every enabled, non-reset, non-clear edge, pop and compare delivered words.
  logic         m_en, m_dv, m_rst, m_clr;
  logic [W-1:0] m_d;
  always @(posedge clk) begin
    m_en  = enabled;
    m_dv  = d_valid;
    m_rst = reset;
    m_clr = clr;
    m_d   = d;
    #1;
    if (m_rst && reset && m_en && !m_clr) begin
      if (q_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL q_unexpected_word: got %0h expected no valid word at %0t", q, $time);
        end else begin
          check("q_word", q, exp_q.pop_front());
        end
      end
      check("d1_q",       q1,       m_d);
      check("d1_q_valid", q1_valid, m_dv);
      check("d1_fill",    fill1,    m_dv);
      check("d1_full",    full1,    m_dv);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] fill_seq [5];
    logic          qv_seq   [4];

    // Reset held low with active inputs: reset state must persist.
    enabled = 1'b1;
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, W'($urandom_range(0, 15)));
      expect_state("reset", '0, 1'b0, '0, 1'b0);
      check("reset_d1_valid", q1_valid, 1'b0);
    end
    @(negedge clk);
    reset   = 1'b1;
    enabled = 1'b0;

    // Latency and fill: words 1..5 back to back, then drain.
    fill_seq = '{1, 2, 3, 4, 4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, W'(i + 1));
      check("lat_fill", fill, fill_seq[i]);
      check("lat_full", full, (i >= 3));
      check("lat_q_valid", q_valid, (i >= 3));
    end
    fill_seq = '{3, 2, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0);
      check("drain_fill", fill, fill_seq[i]);
      check("drain_full", full, 1'b0);
    end

    // Enable hold with fill=2.
    drive(1'b1, 1'b1, 4'hA);
    drive(1'b1, 1'b1, 4'hB);
    check("hold_pre_fill", fill, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, (i % 2) ? 4'hF : 4'h5);
      expect_state("hold", '0, 1'b0, 2, 1'b0);
    end
    drive(1'b1, 1'b1, 4'hC);
    check("resume_fill", fill, 3);
    drive(1'b1, 1'b1, 4'hD);
    expect_state("resume_full", 4'hA, 1'b1, 4, 1'b1);
    fill_seq = '{3, 2, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0);
      check("resume_drain_fill", fill, fill_seq[i]);
    end

    // Mixed valid: invalid words still shift data.
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b1, 4'h3);
    drive(1'b1, 1'b0, 4'h4);
    expect_state("mixed4", 4'h1, 1'b1, 2, 1'b0);
    fill_seq = '{1, 1, 0, 0, 0};
    qv_seq   = '{0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0);
      check("mixed_fill", fill, fill_seq[i]);
      check("mixed_q_valid", q_valid, qv_seq[i]);
      if (i < 3) check("mixed_q_data", q, W'(i + 2));
    end

    // Reset asserted between edges while full.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, W'(i + 5));
    check("pre_reset_full", full, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    expect_state("async_reset", '0, 1'b0, '0, 1'b0);
    check("async_reset_d1_valid", q1_valid, 1'b0);
    exp_q.delete();
    drive(1'b1, 1'b1, 4'hE);
    expect_state("reset_hold", '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset   = 1'b1;
    enabled = 1'b1;
    d_valid = 1'b1;
    d       = 4'h9;
    exp_q.push_back(4'h9);
    @(posedge clk);
    #1;
    check("release_fill", fill, 1);
    fill_seq = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0);
      check("release_drain_fill", fill, fill_seq[i]);
    end

`ifdef FFD_SYNC_CLR_EN
    // Clear while full and disabled: line empties, d is not captured.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, W'(i + 1));
    check("pre_clr_full", full, 1'b1);
    check("pre_clr_d1_full", full1, 1'b1);
    @(negedge clk);
    clr     = 1'b1;
    enabled = 1'b0;
    d_valid = 1'b1;
    d       = 4'h7;
    @(posedge clk);
    #1;
    expect_state("clr", '0, 1'b0, '0, 1'b0);
    check("clr_d1_q", q1, '0);
    check("clr_d1_q_valid", q1_valid, 1'b0);
    check("clr_d1_fill", fill1, 1'b0);
    exp_q.delete();
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0);
      check("post_clr_q_valid", q_valid, 1'b0);
      check("post_clr_fill", fill, 0);
    end
`endif

    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
